mul_shift_add: RTL and testbench

- Multi-cycle unsigned shift-and-add multiplier. Sits directly upstream of the team's ripple-carry adder and drives it: one adder pass per cycle.
- Accepts two WIDTH-bit operands over a valid/ready handshake and returns a 2*WIDTH-bit product.
- Serves as the ALU's MUL/MULHU unit. Small area, no dedicated multiplier array.

---
 rtl/mul_shift_add_pkg.sv | 14 +
 rtl/mul_shift_add_if.sv | 26 ++
 rtl/mul_shift_add_adder.sv | 25 ++
 rtl/mul_shift_add.sv | 108 ++++++++++
 tb/tb_mul_shift_add.sv | 129 ++++++++++++
 5 files changed

// File: rtl/mul_shift_add_pkg.sv
// alu_pkg: shared ALU types and widths used by the multiplier.
// No ports. Optional feature macro elsewhere: MUL_EARLY_TERM_EN.
package alu_pkg;

   localparam int XLEN   = 32;
   localparam int PROD_W = 2 * XLEN;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/mul_shift_add_if.sv
// mul_shift_add_if: operand/product handshake bundle for the multiplier.
// Ports: in_valid/in_ready/a/b (request), out_valid/out_ready/product, busy.
interface mul_shift_add_if #(
   parameter int WIDTH = 32
);

   logic                   in_valid;
   logic                   in_ready;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     product;
   logic                   busy;

   modport master (
      output in_valid, a, b, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, out_ready,
      output in_ready, out_valid, product, busy
   );

endinterface

// File: rtl/mul_shift_add_adder.sv
// adder_32: WIDTH-bit ripple-carry adder with carry-in and carry-out.
// Ports: i_a, i_b (WIDTH), i_cin -> o_sum (WIDTH), o_cout.
module adder_32 #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum,
   output logic             o_cout
);

   logic [WIDTH:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
      assign w_c[g+1]  = (i_a[g] & i_b[g]) |
                         (w_c[g] & (i_a[g] ^ i_b[g]));
   end

   assign o_cout = w_c[WIDTH];

endmodule

// File: rtl/mul_shift_add.sv
// mul_shift_add: multi-cycle unsigned shift-and-add multiplier (MUL/MULHU).
// Ports: clk, rst (sync, active-high), bus (mul_shift_add_if.slave).
// Optional: define MUL_EARLY_TERM_EN to skip iterations once b is exhausted.
module mul_shift_add
   import alu_pkg::*;
#(
   parameter int WIDTH = XLEN,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   mul_shift_add_if.slave  bus
);

   localparam logic [1:0] S_IDLE = MUL_IDLE;
   localparam logic [1:0] S_BUSY = MUL_BUSY;
   localparam logic [1:0] S_DONE = MUL_DONE;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [1:0]         r_state;
   logic [WIDTH-1:0]   r_mcand;
   logic [2*WIDTH-1:0] r_p;
   logic [CNT_W-1:0]   r_cnt;

   logic [WIDTH-1:0]   w_addend;
   logic [WIDTH-1:0]   w_sum;
   logic               w_cout;

   assign w_addend = r_p[0] ? r_mcand : '0;

   adder_32 #(
      .WIDTH (WIDTH)
   ) u_add (
      .i_a    (r_p[2*WIDTH-1:WIDTH]),
      .i_b    (w_addend),
      .i_cin  (1'b0),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

`ifdef MUL_EARLY_TERM_EN
   // r_rem mirrors the multiplier bits not yet consumed; once it is zero
   // every remaining step would only shift P right, so do it in one go.
   logic [WIDTH-1:0]   r_rem;
   logic [CNT_W-1:0]   w_left;

   assign w_left = CNT_W'(WIDTH) - r_cnt;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_mcand <= '0;
         r_p     <= '0;
         r_cnt   <= '0;
`ifdef MUL_EARLY_TERM_EN
         r_rem   <= '0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_mcand <= bus.a;
                  r_p     <= {{WIDTH{1'b0}}, bus.b};
                  r_cnt   <= '0;
                  r_state <= S_BUSY;
`ifdef MUL_EARLY_TERM_EN
                  r_rem   <= bus.b;
`endif
               end
            end
            S_BUSY: begin
`ifdef MUL_EARLY_TERM_EN
               if (r_rem == '0) begin
                  r_p     <= r_p >> w_left;
                  r_cnt   <= CNT_W'(WIDTH);
                  r_state <= S_DONE;
               end else begin
                  r_p   <= {w_cout, w_sum, r_p[WIDTH-1:1]};
                  r_cnt <= r_cnt + CNT_W'(1);
                  r_rem <= r_rem >> 1;
                  if (r_cnt == LAST)
                     r_state <= S_DONE;
               end
`else
               // Carry-out lands in the top bit so the high word is exact.
               r_p   <= {w_cout, w_sum, r_p[WIDTH-1:1]};
               r_cnt <= r_cnt + CNT_W'(1);
               if (r_cnt == LAST)
                  r_state <= S_DONE;
`endif
            end
            S_DONE: begin
               if (bus.out_ready)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_IDLE);
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.busy      = (r_state == S_BUSY);
   assign bus.product   = r_p;

endmodule

// File: tb/tb_mul_shift_add.sv
// tb_mul_shift_add: self-checking bench for mul_shift_add (WIDTH=32).
// Reference product is plain 64-bit multiplication of the operands.
module tb_mul_shift_add;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   int errors = 0;
   int checks = 0;

   mul_shift_add_if #(.WIDTH(W)) bus ();

   mul_shift_add #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic [W-1:0] ta,
                         input logic [W-1:0] tb_v,
                         input int hold,
                         input string tag);
      logic [63:0] exp;
      int n;
      exp = {32'b0, ta} * {32'b0, tb_v};
      @(negedge clk);
      check({tag, "/in_ready"}, 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.a = ta;
      bus.b = tb_v;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.a = $urandom;
      bus.b = $urandom;
      check({tag, "/busy"}, 64'(bus.busy), 64'd1);
      n = 0;
      while (!bus.out_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
`ifdef MUL_EARLY_TERM_EN
      check({tag, "/latency_le"}, 64'(n <= W), 64'd1);
`else
      check({tag, "/latency"}, 64'(n), 64'(W));
`endif
      check({tag, "/product"}, bus.product, exp);
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = i[0];
         bus.a = $urandom;
         bus.b = $urandom;
         @(negedge clk);
         check({tag, "/hold_valid"}, 64'(bus.out_valid), 64'd1);
         check({tag, "/hold_prod"}, bus.product, exp);
         check({tag, "/hold_rdy"}, 64'(bus.in_ready), 64'd0);
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "/idle_rdy"}, 64'(bus.in_ready), 64'd1);
      check({tag, "/idle_ov"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;

      repeat (2) @(negedge clk);
      check("rst/in_ready", 64'(bus.in_ready), 64'd1);
      check("rst/out_valid", 64'(bus.out_valid), 64'd0);
      check("rst/busy", 64'(bus.busy), 64'd0);
      check("rst/product", bus.product, 64'd0);
      rst = 1'b0;

      run_op(32'd3, 32'd5, 0, "3x5");
      run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 0, "max");
      run_op(32'h80000000, 32'd2, 0, "msb");
      run_op(32'd0, 32'h1234, 0, "zero_a");
      run_op(32'h1234, 32'd0, 0, "zero_b");
      run_op(32'd9, 32'd1, 0, "9x1");
      run_op(32'hDEADBEEF, 32'h0BADF00D, 10, "hold");

      // Reset in the middle of an operation.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.a = 32'hFFFF0000;
      bus.b = 32'hFFFFFFFF;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (12) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst/in_ready", 64'(bus.in_ready), 64'd1);
      check("midrst/out_valid", 64'(bus.out_valid), 64'd0);
      check("midrst/busy", 64'(bus.busy), 64'd0);
      check("midrst/product", bus.product, 64'd0);
      run_op(32'd7, 32'd6, 0, "after_rst");

      for (int k = 0; k < 25; k++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = $urandom;
         rb = $urandom;
         if (k % 5 == 0) rb = rb >> (k % 31);
         run_op(ra, rb, k % 3, "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
